// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RV32I core: control-bundle layout and
// register-index constants used by the decode/execute pipeline blocks.
package core_pkg;

    // Control bundle {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, ALUOp[3:0]}
    localparam int unsigned CTRL_W        = 10;
    localparam int unsigned CTRL_REGWRITE = 9;
    localparam int unsigned CTRL_MEMREAD  = 8;
    localparam int unsigned CTRL_MEMWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_ALUSRC   = 5;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_ALUOP_HI = 3;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // Structured view of the control bundle; bit order matches the offsets above.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection (purely combinational).
// Ports:
//   ex_valid, ex_mem_read, ex_rd   - instruction currently in EX
//   id_valid, id_rs1/id_rs2        - instruction currently in ID
//   id_uses_rs1/id_uses_rs2        - which ID source fields are real reads
//   hazard_c                       - ID depends on a load still in EX
module load_use_detect
    import core_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    output logic                 hazard_c
);

    logic rs1_match;
    logic rs2_match;

    // Only fields the instruction actually reads can create a dependency.
    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is never a real destination, so a load to x0 cannot stall.
    assign hazard_c = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) &&
                      id_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall / bubble injection.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   id_*, IF_ID_*          - decoded instruction from ID
//   ex_flush               - taken branch/jump in EX; kill ID instruction
//   hold                   - downstream stall; freeze this register
//   ID_EX_*                - registered operands/control for EX and forwarding
//   load_use_stall         - combinational; hold PC and IF/ID this cycle
//   bubble_cnt, flush_cnt  - wrapping event counters
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_IDX_W-1:0] IF_ID_RegisterRs1,
    input  logic [REG_IDX_W-1:0] IF_ID_RegisterRs2,
    input  logic [REG_IDX_W-1:0] IF_ID_RegisterRd,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [CTRL_W-1:0]    id_ctrl,
    input  logic                 ex_flush,
    input  logic                 hold,
    output logic                 ID_EX_valid,
    output logic [XLEN-1:0]      ID_EX_pc,
    output logic [XLEN-1:0]      ID_EX_rs1_data,
    output logic [XLEN-1:0]      ID_EX_rs2_data,
    output logic [XLEN-1:0]      ID_EX_imm,
    output logic [REG_IDX_W-1:0] ID_EX_RegisterRs1,
    output logic [REG_IDX_W-1:0] ID_EX_RegisterRs2,
    output logic [REG_IDX_W-1:0] ID_EX_RegisterRd,
    output logic [CTRL_W-1:0]    ID_EX_ctrl,
    output logic                 load_use_stall,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic hz_c;
    logic insert_bubble_c;

    load_use_detect u_load_use_detect (
        .ex_valid    (ID_EX_valid),
        .ex_mem_read (ID_EX_ctrl[CTRL_MEMREAD]),
        .ex_rd       (ID_EX_RegisterRd),
        .id_valid    (id_valid),
        .id_rs1      (IF_ID_RegisterRs1),
        .id_rs2      (IF_ID_RegisterRs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .hazard_c    (hz_c)
    );

    // A flush kills the dependent instruction, so there is nothing to stall for.
    assign load_use_stall = hz_c && !ex_flush;

    // Flush beats hold; a load-use bubble waits until hold drops.
    assign insert_bubble_c = ex_flush || (!hold && hz_c);

    // Pipeline register; bubbles clear everything so forwarding never matches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_valid       <= 1'b0;
            ID_EX_pc          <= '0;
            ID_EX_rs1_data    <= '0;
            ID_EX_rs2_data    <= '0;
            ID_EX_imm         <= '0;
            ID_EX_RegisterRs1 <= REG_ZERO;
            ID_EX_RegisterRs2 <= REG_ZERO;
            ID_EX_RegisterRd  <= REG_ZERO;
            ID_EX_ctrl        <= '0;
        end else if (insert_bubble_c) begin
            ID_EX_valid       <= 1'b0;
            ID_EX_pc          <= '0;
            ID_EX_rs1_data    <= '0;
            ID_EX_rs2_data    <= '0;
            ID_EX_imm         <= '0;
            ID_EX_RegisterRs1 <= REG_ZERO;
            ID_EX_RegisterRs2 <= REG_ZERO;
            ID_EX_RegisterRd  <= REG_ZERO;
            ID_EX_ctrl        <= '0;
        end else if (!hold) begin
            ID_EX_valid       <= id_valid;
            ID_EX_pc          <= id_pc;
            ID_EX_rs1_data    <= id_rs1_data;
            ID_EX_rs2_data    <= id_rs2_data;
            ID_EX_imm         <= id_imm;
            ID_EX_RegisterRs1 <= IF_ID_RegisterRs1;
            ID_EX_RegisterRs2 <= IF_ID_RegisterRs2;
            ID_EX_RegisterRd  <= id_valid ? IF_ID_RegisterRd : REG_ZERO;
            ID_EX_ctrl        <= id_valid ? id_ctrl : '0;
        end
    end

    // Event counters, wrapping; hold never blocks a flush or a bubble count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (ex_flush) begin
            flush_cnt  <= flush_cnt + CNT_W'(1);
        end else if (!hold && hz_c) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      if_rs1, if_rs2, if_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [9:0]      id_ctrl;
    logic            ex_flush, hold;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [9:0]      ex_ctrl;
    logic            load_use_stall;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_rs1_data       (id_rs1_data),
        .id_rs2_data       (id_rs2_data),
        .id_imm            (id_imm),
        .IF_ID_RegisterRs1 (if_rs1),
        .IF_ID_RegisterRs2 (if_rs2),
        .IF_ID_RegisterRd  (if_rd),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .id_ctrl           (id_ctrl),
        .ex_flush          (ex_flush),
        .hold              (hold),
        .ID_EX_valid       (ex_valid),
        .ID_EX_pc          (ex_pc),
        .ID_EX_rs1_data    (ex_rs1_data),
        .ID_EX_rs2_data    (ex_rs2_data),
        .ID_EX_imm         (ex_imm),
        .ID_EX_RegisterRs1 (ex_rs1),
        .ID_EX_RegisterRs2 (ex_rs2),
        .ID_EX_RegisterRd  (ex_rd),
        .ID_EX_ctrl        (ex_ctrl),
        .load_use_stall    (load_use_stall),
        .bubble_cnt        (bubble_cnt),
        .flush_cnt         (flush_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] C_LW  = 10'b1_1_0_1_1_0_0000;
    localparam logic [9:0] C_ADD = 10'b1_0_0_0_0_0_0010;

    // Reference model: what EX should hold, as a record
    typedef struct {
        bit         valid;
        bit [31:0]  pc, d1, d2, imm;
        bit [4:0]   rs1, rs2, rd;
        bit [9:0]   ctrl;
    } ex_rec_t;

    ex_rec_t m;
    int      m_bub, m_flu;
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hz();
        bit dep;
        dep = (id_uses_rs1 && if_rs1 == m.rd) || (id_uses_rs2 && if_rs2 == m.rd);
        return m.valid && m.ctrl[8] && m.rd != 0 && id_valid && dep;
    endfunction

    function automatic ex_rec_t bubble();
        ex_rec_t b;
        b = '{default: 0};
        return b;
    endfunction

    task automatic model_reset();
        m = bubble();
        m_bub = 0;
        m_flu = 0;
    endtask

    task automatic model_edge();
        if (ex_flush) begin
            m = bubble();
            m_flu++;
        end else if (hold) begin
            // frozen
        end else if (model_hz()) begin
            m = bubble();
            m_bub++;
        end else begin
            m.valid = id_valid;
            m.pc = id_pc; m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
            m.rs1 = if_rs1; m.rs2 = if_rs2;
            m.rd   = id_valid ? if_rd : 5'd0;
            m.ctrl = id_valid ? id_ctrl : 10'd0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, ".pc"},    ex_pc,         m.pc);
        chk({tag, ".d1"},    ex_rs1_data,   m.d1);
        chk({tag, ".d2"},    ex_rs2_data,   m.d2);
        chk({tag, ".imm"},   ex_imm,        m.imm);
        chk({tag, ".rs1"},   32'(ex_rs1),   32'(m.rs1));
        chk({tag, ".rs2"},   32'(ex_rs2),   32'(m.rs2));
        chk({tag, ".rd"},    32'(ex_rd),    32'(m.rd));
        chk({tag, ".ctrl"},  32'(ex_ctrl),  32'(m.ctrl));
        chk({tag, ".bub"},   32'(bubble_cnt), 32'(m_bub % 16));
        chk({tag, ".flu"},   32'(flush_cnt),  32'(m_flu % 16));
    endtask

    // Stall is checked before the edge, registered state after it.
    task automatic cycle(input string tag);
        #1;
        chk({tag, ".stall"}, 32'(load_use_stall), 32'(model_hz() && !ex_flush));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic set_in(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                          input bit u1, input bit u2, input bit [9:0] c,
                          input bit fl, input bit hd);
        id_valid = v; if_rs1 = r1; if_rs2 = r2; if_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = c;
        ex_flush = fl; hold = hd;
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_outputs("por");
        rst_n = 1'b1;

        // Mid-cycle async reset with a real instruction loaded
        set_in(1, 1, 2, 3, 1, 1, C_ADD, 0, 0);
        cycle("load_pre_rst");
        chk("pre_rst.valid", 32'(ex_valid), 32'd1);
        #2;
        do_reset();
        chk("rst.valid_now", 32'(ex_valid), 32'd0);
        set_in(1, 4, 5, 6, 1, 1, C_ADD, 0, 0);
        cycle("post_rst");
        chk("post_rst.rd", 32'(ex_rd), 32'd6);

        // Flush priority over hold and hazard
        set_in(1, 1, 0, 5, 1, 0, C_LW, 0, 0);
        cycle("fl_lw");
        set_in(1, 5, 7, 6, 1, 1, C_ADD, 1, 1);
        cycle("fl_dep");
        chk("fl.flush_cnt", 32'(flush_cnt), 32'd1);
        chk("fl.bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("fl.valid", 32'(ex_valid), 32'd0);

        // Classic load-use: lw x5 ; add x6,x5,x7
        set_in(1, 1, 0, 5, 1, 0, C_LW, 0, 0);
        cycle("lu_lw");
        set_in(1, 5, 7, 6, 1, 0, C_ADD, 0, 0);
        #1;
        chk("lu.stall_now", 32'(load_use_stall), 32'd1);
        cycle("lu_bubble");
        chk("lu.valid", 32'(ex_valid), 32'd0);
        chk("lu.ctrl", 32'(ex_ctrl), 32'd0);
        chk("lu.bubble_cnt", 32'(bubble_cnt), 32'd1);
        cycle("lu_reenter");
        chk("lu.rs1", 32'(ex_rs1), 32'd5);
        chk("lu.valid2", 32'(ex_valid), 32'd1);

        // lw x0 then reader of x0
        set_in(1, 1, 0, 0, 1, 0, C_LW, 0, 0);
        cycle("x0_lw");
        set_in(1, 0, 0, 6, 1, 1, C_ADD, 0, 0);
        #1;
        chk("x0.stall", 32'(load_use_stall), 32'd0);
        cycle("x0_rd");

        // rs2 field matches but is not read
        set_in(1, 1, 0, 5, 1, 0, C_LW, 0, 0);
        cycle("u2_lw");
        set_in(1, 9, 5, 6, 1, 0, C_ADD, 0, 0);
        #1;
        chk("u2.stall", 32'(load_use_stall), 32'd0);
        cycle("u2_rd");

        // Hold for 3 cycles with hazard pending
        set_in(1, 1, 0, 5, 1, 0, C_LW, 0, 0);
        cycle("hd_lw");
        set_in(1, 2, 5, 6, 0, 1, C_ADD, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hd.stall", 32'(load_use_stall), 32'd1);
            cycle("hd_frozen");
            chk("hd.rd_frozen", 32'(ex_rd), 32'd5);
        end
        hold = 1'b0;
        cycle("hd_release");
        chk("hd.valid", 32'(ex_valid), 32'd0);
        chk("hd.bub", 32'(bubble_cnt), 32'd2);
        cycle("hd_reenter");
        chk("hd.bub_once", 32'(bubble_cnt), 32'd2);

        // Randomized traffic biased towards hazards
        for (int i = 0; i < 400; i++) begin
            bit [9:0] c;
            c = 10'($urandom);
            if ($urandom_range(0, 1) == 0) c[8] = 1'b1;
            set_in(1'($urandom_range(0, 4) != 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), c,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
            cycle("rnd");
            if (!ex_valid)
                chk("rnd.bubble_inv", 32'({ex_ctrl[9:7], ex_rd}), 32'd0);
        end

        // Counter wrap: 16 load-use pairs
        #2;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(1, 1, 0, 5, 1, 0, C_LW, 0, 0);
            cycle("wr_lw");
            set_in(1, 5, 3, 6, 1, 1, C_ADD, 0, 0);
            cycle("wr_bub");
            cycle("wr_dep");
        end
        chk("wrap.bubble_cnt", 32'(bubble_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core.
- Captures decoded operands/control from ID and detects load-use dependencies against the instruction currently in EX.
- On a dependency, stalls PC and IF/ID and injects a bubble into EX.
- Its ID_EX_RegisterRs1/Rs2, ID_EX_RegisterRd and control outputs feed the forwarding unit and the EX-stage operand muxes directly.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the bubble/flush performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1_data  in  XLEN  register-file read port 1.
- id_rs2_data  in  XLEN  register-file read port 2.
- id_imm  in  XLEN  sign-extended immediate.
- IF_ID_RegisterRs1  in  5  source register 1 of ID instruction.
- IF_ID_RegisterRs2  in  5  source register 2 of ID instruction.
- IF_ID_RegisterRd  in  5  destination register of ID instruction.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_ctrl  in  10  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, ALUOp[3:0]}.
- ex_flush  in  1  branch/jump taken in EX; kill ID instruction.
- hold  in  1  downstream (memory) stall; freeze this register.
- ID_EX_valid  out  1  EX instruction valid.
- ID_EX_pc  out  XLEN  registered id_pc.
- ID_EX_rs1_data  out  XLEN  registered id_rs1_data.
- ID_EX_rs2_data  out  XLEN  registered id_rs2_data.
- ID_EX_imm  out  XLEN  registered id_imm.
- ID_EX_RegisterRs1  out  5  registered rs1.
- ID_EX_RegisterRs2  out  5  registered rs2.
- ID_EX_RegisterRd  out  5  registered rd.
- ID_EX_ctrl  out  10  registered control.
- load_use_stall  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_cnt  out  CNT_W  load-use bubbles inserted.
- flush_cnt  out  CNT_W  flushes applied.

Behaviour:
- Reset: asynchronous on rst_n low. All registered outputs and counters become 0, so the stage holds a NOP bubble.
- Hazard term: hz = ID_EX_valid & ID_EX_ctrl.MemRead & (ID_EX_RegisterRd != 0) & id_valid & ((id_uses_rs1 & IF_ID_RegisterRs1 == ID_EX_RegisterRd) | (id_uses_rs2 & IF_ID_RegisterRs2 == ID_EX_RegisterRd)).
- Stall output: load_use_stall = hz & ~ex_flush.
  - Combinational, same cycle.
  - A flush kills the dependent instruction, so no stall is raised.
- Per rising edge, first match wins:
  1. ex_flush: load bubble (valid=0, ctrl=0, Rd=0, Rs1=0, Rs2=0; data fields don't-care, held at 0); flush_cnt += 1. Flush overrides hold.
  2. hold: all registers keep their value; counters unchanged.
  3. hz: load bubble; bubble_cnt += 1. IF/ID is held externally, so the dependent instruction re-enters on the next edge.
  4. Otherwise: load all ID inputs; ID_EX_valid = id_valid. When id_valid=0, force ctrl=0 and Rd=0.
- Bubble invariant: whenever ID_EX_valid=0, ID_EX_ctrl.RegWrite, MemRead and MemWrite are 0 and ID_EX_RegisterRd is 0. This guarantees the forwarding unit never matches a bubble.
- Stall duration: a load-use stall lasts exactly one cycle. After the bubble, the load is in MEM and the forwarding unit supplies the value via the MEM/WB path on the following cycle.
- hold with hz true: load_use_stall stays asserted for every cycle of hold, and the bubble is inserted on the first edge where hold=0.
- x0: a load with rd=x0 never stalls.
- Counters: wrap modulo 2^CNT_W with no saturation. They are not affected by hold.
- Latency: one cycle from ID inputs to ID_EX outputs. No combinational path from ID inputs to ID_EX outputs.

Decomposition:
- Shared package core_pkg holds:
  - Control-bundle field offsets: CTRL_REGWRITE=9, CTRL_MEMREAD=8, CTRL_MEMWRITE=7, CTRL_MEMTOREG=6, CTRL_ALUSRC=5, CTRL_BRANCH=4, CTRL_ALUOP=3:0.
  - CTRL_W=10.
  - REG_ZERO=5'd0.
- One sub-module: load_use_detect (purely combinational hz computation), reused later by a dual-issue variant.
- Counters and register are inline.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with valid inputs loaded → all outputs 0 immediately, without waiting for a clock edge. Release → next edge captures ID.
- Load-use: EX holds lw x5 (MemRead=1, Rd=5), ID holds add x6,x5,x7 (uses_rs1=1) → load_use_stall=1; next edge ID_EX_valid=0, ctrl=0; bubble_cnt=1. Following edge captures add with Rs1=5.
- No stall cases:
  - lw x0 followed by a reader of x0 → load_use_stall=0.
  - lw x5 followed by an instruction with uses_rs2=0 and rs2 field=5 → load_use_stall=0.
- Flush priority: ex_flush=1 with hold=1 and hz=1 → load_use_stall=0; next edge bubble; flush_cnt=1, bubble_cnt=0.
- Hold: hold=1 for 3 cycles with hz=1 → outputs frozen and load_use_stall=1 for all 3 cycles. First edge after hold drops → bubble; bubble_cnt increments once only.
- Counter wrap: CNT_W=4, 16 consecutive load-use pairs → bubble_cnt returns to 0.
